// File: rtl/masurare_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : masurare_pkg                                            |
// | Purpose  : Shared types and constants for the tick period meter    |
// |            and its front-end edge detector.                        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package masurare_pkg;

   // Measurement FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2
   } state_t;

   // Default width of the cycle counter / period output
   localparam int unsigned DEF_CNT_W = 32;

   // Width of the consecutive-match counter; holds lock targets up to 15
   localparam int unsigned LOCK_W = 4;

endpackage : masurare_pkg
`default_nettype wire

// File: rtl/detector_front.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : detector_front                                          |
// | Purpose  : Registered rising-edge detector for a synchronous tick. |
// |            A tick held high for several cycles yields one edge.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module detector_front (
   input  logic clk_i,
   input  logic reset_i,
   input  logic tick_i,
   output logic edge_o
);

   logic tick_q;
   logic tick_d;

   // Next value of the delayed tick is simply the current tick
   always_comb begin
      tick_d = tick_i;
   end

   // Delay the tick by one clock so a low-to-high transition can be seen
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign edge_o = tick_i & ~tick_q;

endmodule : detector_front
`default_nettype wire

// File: rtl/masurare_perioada.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : masurare_perioada                                       |
// | Purpose  : Measures clk_i cycles between consecutive tick rising   |
// |            edges, strobes each result, tracks lock on a stable     |
// |            period and flags a sticky timeout when ticks stop.      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module masurare_perioada
   import masurare_pkg::*;
#(
   parameter int unsigned      CNT_W      = DEF_CNT_W,
   parameter int unsigned      LOCK_CNT   = 4,
   parameter logic [CNT_W-1:0] MAX_PERIOD = {CNT_W{1'b1}}
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable,
   input  logic             tick_i,
   output logic [CNT_W-1:0] period_o,
   output logic             valid_o,
   output logic             locked_o,
   output logic             timeout_o
);

   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [LOCK_W-1:0] MATCH_ONE = LOCK_W'(1);
   localparam logic [LOCK_W-1:0] LOCK_TGT  = LOCK_W'(LOCK_CNT);

   state_t            state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [CNT_W-1:0]  period_q,    period_d;
   logic [LOCK_W-1:0] match_cnt_q, match_cnt_d;
   logic              valid_q,     valid_d;
   logic              locked_q,    locked_d;
   logic              timeout_q,   timeout_d;

   logic              tick_edge;
   logic [LOCK_W-1:0] match_meas;
   logic              locked_meas;

   detector_front u_detector_front (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .tick_i  (tick_i),
      .edge_o  (tick_edge)
   );

   // Lock bookkeeping for a measurement taken this cycle: a repeat of the
   // previous period extends the run (saturating), anything else restarts it
   always_comb begin
      match_meas = MATCH_ONE;
      if ((match_cnt_q != '0) && (cnt_q == period_q)) begin
         if (match_cnt_q == LOCK_TGT) begin
            match_meas = match_cnt_q;
         end else begin
            match_meas = match_cnt_q + MATCH_ONE;
         end
      end
      locked_meas = (match_meas == LOCK_TGT);
   end

   // Next-state and datapath: enable low overrides everything, then the
   // FSM arms on the first edge and measures between subsequent edges
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      match_cnt_d = match_cnt_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      timeout_d   = timeout_q;

      if (!enable) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         match_cnt_d = '0;
         locked_d    = 1'b0;
         timeout_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d       = '0;
               match_cnt_d = '0;
               locked_d    = 1'b0;
               timeout_d   = 1'b0;
               state_d     = ST_ARMED;
            end
            ST_ARMED: begin
               if (tick_edge) begin
                  cnt_d   = CNT_ONE;
                  state_d = ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               // An edge coinciding with the counter limit is a valid
               // measurement of MAX_PERIOD, so the edge is checked first
               if (tick_edge) begin
                  period_d    = cnt_q;
                  valid_d     = 1'b1;
                  cnt_d       = CNT_ONE;
                  timeout_d   = 1'b0;
                  match_cnt_d = match_meas;
                  locked_d    = locked_meas;
               end else if (cnt_q == MAX_PERIOD) begin
                  // Stop counting rather than wrap; re-arm on the next edge
                  timeout_d   = 1'b1;
                  locked_d    = 1'b0;
                  match_cnt_d = '0;
                  cnt_d       = '0;
                  state_d     = ST_ARMED;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         period_q    <= '0;
         match_cnt_q <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         match_cnt_q <= match_cnt_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         timeout_q   <= timeout_d;
      end
   end

   assign period_o  = period_q;
   assign valid_o   = valid_q;
   assign locked_o  = locked_q;
   assign timeout_o = timeout_q;

endmodule : masurare_perioada
`default_nettype wire

// File: tb/tb_masurare_perioada.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_masurare_perioada                                    |
// | Purpose  : Directed self-checking bench for the tick period meter. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_masurare_perioada;

   logic       clk     = 1'b0;
   logic       reset_i = 1'b1;
   logic       enable  = 1'b0;
   logic       tick_i  = 1'b0;
   logic [3:0] period_o;
   logic       valid_o;
   logic       locked_o;
   logic       timeout_o;

   int total = 0;
   int bad   = 0;

   // Results captured by send_period
   logic       sv;
   logic [3:0] sp;
   logic       sl;
   logic       st;
   int         snv;

   masurare_perioada #(
      .CNT_W      (4),
      .LOCK_CNT   (4),
      .MAX_PERIOD (4'd15)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset_i),
      .enable    (enable),
      .tick_i    (tick_i),
      .period_o  (period_o),
      .valid_o   (valid_o),
      .locked_o  (locked_o),
      .timeout_o (timeout_o)
   );

   always #5 clk = ~clk;

   // Hold tick at a fixed level for n clocks
   task automatic hold(input logic t, input int n);
      for (int i = 0; i < n; i++) begin
         tick_i = t;
         @(posedge clk);
         #1;
      end
   endtask

   // One tick period: high for 'high' clocks then low; outputs sampled right
   // after the first clock (the one that sees the rising edge) are returned
   task automatic send_period(input int per, input int high,
                              output logic v, output logic [3:0] p,
                              output logic l, output logic t, output int nv);
      nv = 0;
      v = 1'b0; p = '0; l = 1'b0; t = 1'b0;
      for (int i = 0; i < per; i++) begin
         tick_i = (i < high);
         @(posedge clk);
         #1;
         if (i == 0) begin
            v = valid_o; p = period_o; l = locked_o; t = timeout_o;
         end
         if (valid_o) nv++;
      end
   endtask

   task automatic test_reset;
      reset_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({period_o, valid_o, locked_o, timeout_o} !== 7'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=0000000",
                  {period_o, valid_o, locked_o, timeout_o});
      end
      reset_i = 1'b0;
   endtask

   task automatic test_stable;
      enable = 1'b1;
      hold(1'b0, 1);
      send_period(5, 1, sv, sp, sl, st, snv);
      total++;
      if (sv !== 1'b0) begin
         bad++; $display("FAIL stable_arm_edge valid got=%b exp=0", sv);
      end
      for (int k = 2; k <= 6; k++) begin
         send_period(5, 1, sv, sp, sl, st, snv);
         total++;
         if (sv !== 1'b1 || sp !== 4'd5 || snv !== 1 || sl !== (k >= 5)) begin
            bad++;
            $display("FAIL stable_k%0d got v=%b p=%0d nv=%0d l=%b exp v=1 p=5 nv=1 l=%b",
                     k, sv, sp, snv, sl, (k >= 5));
         end
      end
   endtask

   task automatic test_period_change;
      send_period(6, 1, sv, sp, sl, st, snv);
      total++;
      if (sp !== 4'd5 || sl !== 1'b1) begin
         bad++; $display("FAIL change_last5 got p=%0d l=%b exp p=5 l=1", sp, sl);
      end
      for (int k = 2; k <= 5; k++) begin
         send_period(6, 1, sv, sp, sl, st, snv);
         total++;
         if (sv !== 1'b1 || sp !== 4'd6 || sl !== (k == 5)) begin
            bad++;
            $display("FAIL change_k%0d got v=%b p=%0d l=%b exp v=1 p=6 l=%b",
                     k, sv, sp, sl, (k == 5));
         end
      end
   endtask

   task automatic test_level;
      send_period(10, 3, sv, sp, sl, st, snv);
      for (int k = 1; k <= 3; k++) begin
         send_period(10, 3, sv, sp, sl, st, snv);
         total++;
         if (sv !== 1'b1 || sp !== 4'd10 || snv !== 1) begin
            bad++;
            $display("FAIL level_k%0d got v=%b p=%0d nv=%0d exp v=1 p=10 nv=1",
                     k, sv, sp, snv);
         end
      end
   endtask

   task automatic test_timeout;
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      hold(1'b0, 1);
      for (int k = 1; k <= 7; k++) send_period(5, 1, sv, sp, sl, st, snv);
      total++;
      if (sl !== 1'b1 || sp !== 4'd5) begin
         bad++; $display("FAIL timeout_prelock got l=%b p=%0d exp l=1 p=5", sl, sp);
      end
      hold(1'b0, 10);
      total++;
      if (timeout_o !== 1'b0 || locked_o !== 1'b1) begin
         bad++;
         $display("FAIL timeout_early got t=%b l=%b exp t=0 l=1", timeout_o, locked_o);
      end
      hold(1'b0, 1);
      total++;
      if (timeout_o !== 1'b1 || locked_o !== 1'b0) begin
         bad++;
         $display("FAIL timeout_fire got t=%b l=%b exp t=1 l=0", timeout_o, locked_o);
      end
      send_period(7, 1, sv, sp, sl, st, snv);
      total++;
      if (sv !== 1'b0 || st !== 1'b1) begin
         bad++; $display("FAIL timeout_rearm got v=%b t=%b exp v=0 t=1", sv, st);
      end
      send_period(7, 1, sv, sp, sl, st, snv);
      total++;
      if (sv !== 1'b1 || sp !== 4'd7 || st !== 1'b0) begin
         bad++;
         $display("FAIL timeout_recover got v=%b p=%0d t=%b exp v=1 p=7 t=0", sv, sp, st);
      end
   endtask

   task automatic test_max_boundary;
      send_period(15, 1, sv, sp, sl, st, snv);
      total++;
      if (timeout_o !== 1'b0 || snv !== 1) begin
         bad++;
         $display("FAIL max_span got t=%b nv=%0d exp t=0 nv=1", timeout_o, snv);
      end
      send_period(5, 1, sv, sp, sl, st, snv);
      total++;
      if (sv !== 1'b1 || sp !== 4'd15 || st !== 1'b0) begin
         bad++;
         $display("FAIL max_edge_wins got v=%b p=%0d t=%b exp v=1 p=15 t=0", sv, sp, st);
      end
   endtask

   task automatic test_enable_drop;
      for (int k = 2; k <= 6; k++) send_period(5, 1, sv, sp, sl, st, snv);
      total++;
      if (sl !== 1'b1) begin
         bad++; $display("FAIL en_prelock got l=%b exp l=1", sl);
      end
      enable = 1'b0;
      tick_i = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (valid_o !== 1'b0 || locked_o !== 1'b0 || timeout_o !== 1'b0 || period_o !== 4'd5) begin
         bad++;
         $display("FAIL en_drop got v=%b l=%b t=%b p=%0d exp v=0 l=0 t=0 p=5",
                  valid_o, locked_o, timeout_o, period_o);
      end
      hold(1'b0, 3);
      send_period(5, 1, sv, sp, sl, st, snv);
      send_period(5, 1, sv, sp, sl, st, snv);
      total++;
      if (snv !== 0 || period_o !== 4'd5) begin
         bad++;
         $display("FAIL en_idle got nv=%0d p=%0d exp nv=0 p=5", snv, period_o);
      end
   endtask

   task automatic test_reset_mid;
      enable = 1'b1;
      hold(1'b0, 1);
      send_period(6, 1, sv, sp, sl, st, snv);
      send_period(5, 1, sv, sp, sl, st, snv);
      total++;
      if (sv !== 1'b1 || sp !== 4'd6) begin
         bad++; $display("FAIL rst_pre got v=%b p=%0d exp v=1 p=6", sv, sp);
      end
      hold(1'b1, 1);
      hold(1'b0, 1);
      #2;
      reset_i = 1'b1;
      #1;
      total++;
      if ({period_o, valid_o, locked_o, timeout_o} !== 7'd0) begin
         bad++;
         $display("FAIL rst_async got=%b exp=0000000",
                  {period_o, valid_o, locked_o, timeout_o});
      end
      #2;
      reset_i = 1'b0;
      hold(1'b0, 1);
      send_period(5, 1, sv, sp, sl, st, snv);
      total++;
      if (sv !== 1'b0 || snv !== 0) begin
         bad++; $display("FAIL rst_first_edge got v=%b nv=%0d exp v=0 nv=0", sv, snv);
      end
      send_period(5, 1, sv, sp, sl, st, snv);
      total++;
      if (sv !== 1'b1 || sp !== 4'd5) begin
         bad++; $display("FAIL rst_after got v=%b p=%0d exp v=1 p=5", sv, sp);
      end
   endtask

   initial begin
      test_reset();
      test_stable();
      test_period_change();
      test_level();
      test_timeout();
      test_max_boundary();
      test_enable_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_masurare_perioada
`default_nettype wire
